instr_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer at the front of the single-cycle CPU.

---
 rtl/instr_fetch_unit_if.sv | 10 +
 rtl/instr_fetch_unit.sv | 75 +++++++
 tb/tb_instr_fetch_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: request and word address out, data and busy-wait back.
interface instr_fetch_unit_if;
    logic        read;
    logic [29:0] addr;
    logic [31:0] rdata;
    logic        busywait;

    modport master (output read, output addr, input rdata, input busywait);
    modport slave  (input read, input addr, output rdata, output busywait);
endinterface

// File: rtl/instr_fetch_unit.sv
// PC register and two-state fetch sequencer: fetch from a busy-wait instruction memory,
// then hold the instruction for execute until the datapath lets the PC advance.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          next_pc,
    input  logic                 cpu_stall,
    output logic [31:0]          pc,
    output logic [31:0]          instruction,
    output logic                 instr_valid,
    output logic                 stall,
    instr_fetch_unit_if.master   imem,
    output logic                 align_err,
    output logic [CNT_W-1:0]     retired
);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t state, state_nxt;
    logic   load_instr;
    logic   advance;

    always_comb begin
        state_nxt  = state;
        load_instr = 1'b0;
        advance    = 1'b0;
        case (state)
            FETCH: begin
                if (!imem.busywait) begin
                    load_instr = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (!cpu_stall) begin
                    advance   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // The request is gated by reset so an aborted fetch drops immediately, without a clock edge.
    assign imem.read   = (state == FETCH) && rst_n;
    assign imem.addr   = pc[31:2];
    assign stall       = (state == FETCH);
    assign instr_valid = (state == EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instruction <= 32'h0000_0000;
            align_err   <= 1'b0;
            retired     <= '0;
        end else begin
            state <= state_nxt;
            if (load_instr) begin
                instruction <= imem.rdata;
            end
            if (advance) begin
                pc      <= {next_pc[31:2], 2'b00};
                retired <= retired + CNT_W'(1);
                if (next_pc[1:0] != 2'b00) begin
                    align_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit; memory returns 32'h0A01 + byte address.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] nextPc;
    logic        cpuStall;
    logic        busy;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instrValid;
    logic        stall;
    logic        alignErr;
    logic [3:0]  retired;

    int vecCount  = 0;
    int missCount = 0;

    instr_fetch_unit_if imemIf ();

    assign imemIf.busywait = busy;
    assign imemIf.rdata    = 32'h0000_0A01 + {imemIf.addr, 2'b00};

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (nextPc),
        .cpu_stall   (cpuStall),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instrValid),
        .stall       (stall),
        .imem        (imemIf.master),
        .align_err   (alignErr),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic        cstall;
        logic        busy;
        logic [31:0] ePc;
        logic        eValid;
        logic [31:0] eInstr;
        logic        eAlign;
        logic [3:0]  eRet;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mkVec(input string n, input logic [31:0] npc, input logic cs,
                                   input logic bw, input logic [31:0] ePc, input logic eValid,
                                   input logic [31:0] eInstr, input logic eAlign, input logic [3:0] eRet);
        vec_t v;
        v.name = n; v.npc = npc; v.cstall = cs; v.busy = bw;
        v.ePc = ePc; v.eValid = eValid; v.eInstr = eInstr; v.eAlign = eAlign; v.eRet = eRet;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] ePc, input logic eValid,
                               input logic eRead, input logic eStall, input logic [31:0] eInstr,
                               input logic eAlign, input logic [3:0] eRet);
        logic [29:0] eAddr;
        logic        ok;
        eAddr = ePc[31:2];
        ok = (pc === ePc) && (instrValid === eValid) && (imemIf.read === eRead) &&
             (stall === eStall) && (instruction === eInstr) && (alignErr === eAlign) &&
             (retired === eRet) && (!eRead || imemIf.addr === eAddr);
        vecCount++;
        if (!ok) begin
            missCount++;
            $display("[TB] FAIL %s: got pc=%h v=%b rd=%b st=%b addr=%h ins=%h al=%b ret=%0d; exp pc=%h v=%b rd=%b st=%b addr=%h ins=%h al=%b ret=%0d",
                     name, pc, instrValid, imemIf.read, stall, imemIf.addr, instruction, alignErr, retired,
                     ePc, eValid, eRead, eStall, eAddr, eInstr, eAlign, eRet);
        end
    endtask

    // One clock per vector: drive on the falling edge, check on the next falling edge.
    task automatic applyStimulus(input vec_t v);
        nextPc   = v.npc;
        cpuStall = v.cstall;
        busy     = v.busy;
        @(posedge clk);
        @(negedge clk);
        checkOutput(v.name, v.ePc, v.eValid, !v.eValid, !v.eValid, v.eInstr, v.eAlign, v.eRet);
    endtask

    initial begin
        logic [31:0] expPc;
        logic [3:0]  expRet;

        rst_n = 1'b0; nextPc = '0; cpuStall = 1'b0; busy = 1'b0;

        vecs[0]  = mkVec("t1_accept",      32'h0,         0, 0, 32'h0,         1, 32'h0000_0A01, 0, 4'd0);
        vecs[1]  = mkVec("t1_retire",      32'h4,         0, 0, 32'h4,         0, 32'h0000_0A01, 0, 4'd1);
        vecs[2]  = mkVec("t2_wait1_ignore",32'h100,       1, 1, 32'h4,         0, 32'h0000_0A01, 0, 4'd1);
        vecs[3]  = mkVec("t2_wait2",       32'h100,       0, 1, 32'h4,         0, 32'h0000_0A01, 0, 4'd1);
        vecs[4]  = mkVec("t2_wait3",       32'h100,       0, 1, 32'h4,         0, 32'h0000_0A01, 0, 4'd1);
        vecs[5]  = mkVec("t2_accept",      32'h100,       0, 0, 32'h4,         1, 32'h0000_0A05, 0, 4'd1);
        vecs[6]  = mkVec("t4_stall1",      32'h8,         1, 0, 32'h4,         1, 32'h0000_0A05, 0, 4'd1);
        vecs[7]  = mkVec("t4_stall2",      32'h8,         1, 1, 32'h4,         1, 32'h0000_0A05, 0, 4'd1);
        vecs[8]  = mkVec("t4_stall3",      32'h8,         1, 0, 32'h4,         1, 32'h0000_0A05, 0, 4'd1);
        vecs[9]  = mkVec("t4_stall4",      32'h8,         1, 0, 32'h4,         1, 32'h0000_0A05, 0, 4'd1);
        vecs[10] = mkVec("t4_release",     32'h10,        0, 0, 32'h10,        0, 32'h0000_0A05, 0, 4'd2);
        vecs[11] = mkVec("t3_fetch10",     32'h0,         0, 0, 32'h10,        1, 32'h0000_0A11, 0, 4'd2);
        vecs[12] = mkVec("t3_branch_back", 32'h0C,        0, 0, 32'h0C,        0, 32'h0000_0A11, 0, 4'd3);
        vecs[13] = mkVec("t3_fetch0c",     32'h0,         0, 0, 32'h0C,        1, 32'h0000_0A0D, 0, 4'd3);
        vecs[14] = mkVec("t5_misalign",    32'h22,        0, 0, 32'h20,        0, 32'h0000_0A0D, 1, 4'd4);
        vecs[15] = mkVec("t5_fetch20",     32'h0,         0, 0, 32'h20,        1, 32'h0000_0A21, 1, 4'd4);
        vecs[16] = mkVec("t5_sticky",      32'h24,        0, 0, 32'h24,        0, 32'h0000_0A21, 1, 4'd5);
        vecs[17] = mkVec("t5_fetch24",     32'h0,         0, 0, 32'h24,        1, 32'h0000_0A25, 1, 4'd5);
        vecs[18] = mkVec("pc_top",         32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 32'h0000_0A25, 1, 4'd6);
        vecs[19] = mkVec("pc_top_fetch",   32'h0,         0, 0, 32'hFFFF_FFFC, 1, 32'h0000_09FD, 1, 4'd6);
        vecs[20] = mkVec("pc_wrap_zero",   32'h0,         0, 0, 32'h0,         0, 32'h0000_09FD, 1, 4'd7);

        #3;
        checkOutput("reset_state", 32'h0, 0, 0, 1, 32'h0, 0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t1_fetch_req", 32'h0, 0, 1, 1, 32'h0, 0, 4'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Retire until the 4-bit counter wraps 15 -> 0; sticky align flag stays set.
        expPc  = 32'h0;
        expRet = 4'd7;
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(mkVec("t7_fetch", 32'h0, 0, 0, expPc, 1, 32'h0000_0A01 + expPc, 1, expRet));
            expRet = expRet + 4'd1;
            applyStimulus(mkVec("t7_retire", 32'h4 * k, 0, 0, 32'h4 * k,
                                0, 32'h0000_0A01 + expPc, 1, expRet));
            expPc = 32'h4 * k;
        end

        // Reset asserted in the middle of a busy-wait fetch of word 9.
        busy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_waiting", 32'h24, 0, 1, 1, 32'h0000_0A21, 1, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_reset", 32'h0, 0, 0, 1, 32'h0, 0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t6_refetch_req", 32'h0, 0, 1, 1, 32'h0, 0, 4'd0);
        applyStimulus(mkVec("t6_refetch", 32'h0, 0, 0, 32'h0, 1, 32'h0000_0A01, 0, 4'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
